// File: rtl/loop_sequencer_if.sv
// loop_sequencer_if: step request handshake between the loop sequencer
// and the execution resource it drives.
//   step_valid : step request (master -> slave)
//   step_index : zero-based number of the requested step (master -> slave)
//   step_ack   : step accepted this cycle (slave -> master)
interface loop_sequencer_if #(
    parameter int WIDTH = 5
);
    logic             step_valid;
    logic             step_ack;
    logic [WIDTH-1:0] step_index;

    modport master (
        output step_valid,
        output step_index,
        input  step_ack
    );

    modport slave (
        input  step_valid,
        input  step_index,
        output step_ack
    );
endinterface

// File: rtl/loop_sequencer.sv
// loop_sequencer: count-down iteration initiator issuing one step per
// iteration over a valid/ack handshake, ending with a one-cycle done.
//   clk, reset_n     : clock, async active-low reset
//   start, count_in  : begin a loop of count_in steps (IDLE only)
//   abort            : end the loop early (RUN only)
//   step             : master side of the step handshake
//   remaining        : steps not yet acknowledged
//   busy, done       : loop in progress / one-cycle completion pulse
//   aborted          : last loop ended through abort
module loop_sequencer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] count_in,
    input  logic             abort,
    loop_sequencer_if.master step,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             ab_q, ab_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            ab_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            ab_q    <= ab_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        ab_d    = ab_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ab_d = 1'b0;
                    if (count_in != '0) begin
                        rem_d   = count_in;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        rem_d   = '0;
                        state_d = FINISH;
                    end
                end
            end
            RUN: begin
                // An ack in the abort cycle is counted first; finishing
                // the last step that way is a normal completion.
                if (step.step_ack) begin
                    idx_d = idx_q + WIDTH'(1);
                    rem_d = rem_q - WIDTH'(1);
                    if (rem_q == WIDTH'(1)) begin
                        state_d = FINISH;
                    end else if (abort) begin
                        ab_d    = 1'b1;
                        state_d = FINISH;
                    end
                end else if (abort) begin
                    ab_d    = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign step.step_valid = (state_q == RUN);
    assign step.step_index = idx_q;
    assign remaining       = rem_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FINISH);
    assign aborted         = ab_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: directed and random stimulus for loop_sequencer,
// compared each cycle against a queue-based loop model.
module tb_loop_sequencer;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] count_in = '0;
    logic         abort = 1'b0;
    logic [W-1:0] remaining;
    logic         busy, done, aborted;

    int vectors = 0;
    int errors  = 0;

    loop_sequencer_if #(.WIDTH(W)) bus ();

    loop_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .count_in  (count_in),
        .abort     (abort),
        .step      (bus),
        .remaining (remaining),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    // Model: the loop is a queue of step numbers still to be acknowledged.
    logic [W-1:0] q[$];
    logic [W-1:0] m_idx;
    bit           m_run, m_fin, m_ab;

    task automatic model_reset();
        q.delete();
        m_idx = '0;
        m_run = 0;
        m_fin = 0;
        m_ab  = 0;
    endtask

    task automatic model_step(input bit s, input logic [W-1:0] c,
                              input bit a, input bit k);
        logic [W-1:0] popped;
        if (m_fin) begin
            m_fin = 0;
        end else if (m_run) begin
            if (k) begin
                popped = q.pop_front();
                m_idx  = popped + W'(1);
            end
            if (q.size() == 0) begin
                m_run = 0;
                m_fin = 1;
                m_ab  = 0;
            end else if (a) begin
                m_run = 0;
                m_fin = 1;
                m_ab  = 1;
            end
        end else if (s) begin
            m_ab = 0;
            q.delete();
            for (int i = 0; i < int'(c); i++) q.push_back(W'(i));
            if (c != 0) begin
                m_idx = '0;
                m_run = 1;
            end else begin
                m_fin = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_ctl"},
              {28'd0, bus.step_valid, busy, done, aborted},
              {28'd0, m_run, m_run | m_fin, m_fin, m_ab});
        check({tag, "_idx"}, {27'd0, bus.step_index}, {27'd0, m_idx});
        check({tag, "_rem"}, {27'd0, remaining}, q.size());
        check({tag, "_excl"}, {31'd0, done & bus.step_valid}, 32'd0);
    endtask

    task automatic cycle(input string tag, input bit s,
                         input logic [W-1:0] c, input bit a, input bit k);
        start        = s;
        count_in     = c;
        abort        = a;
        bus.step_ack = k;
        @(posedge clk);
        model_step(s, c, a, k);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 0, '0, 0, 0);
    endtask

    initial begin
        bus.step_ack = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #4;

        cycle("basic", 1, 5'd3, 0, 1);
        for (int i = 0; i < 4; i++) cycle("basic", 0, '0, 0, 1);
        idle("basic_idle", 1);

        cycle("zero", 1, 5'd0, 0, 0);
        idle("zero", 3);

        cycle("stall", 1, 5'd2, 0, 0);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 3; i++) cycle("stall", 0, '0, 0, 0);
            cycle("stall_ack", 0, '0, 0, 1);
        end
        idle("stall_end", 2);

        cycle("abort31", 1, 5'd31, 0, 1);
        cycle("abort31", 0, '0, 0, 1);
        cycle("abort31", 0, '0, 0, 1);
        cycle("abort31_hit", 0, '0, 1, 1);
        check("abort31_rem", {27'd0, remaining}, 32'd28);
        check("abort31_idx", {27'd0, bus.step_index}, 32'd3);
        check("abort31_ab", {31'd0, aborted & done}, 32'd1);
        idle("abort31_end", 2);

        cycle("abortlast", 1, 5'd2, 0, 0);
        cycle("abortlast", 0, '0, 0, 1);
        cycle("abortlast_hit", 0, '0, 1, 1);
        check("abortlast_ab", {31'd0, aborted}, 32'd0);
        idle("abortlast_end", 2);

        cycle("ign_run", 1, 5'd3, 0, 0);
        cycle("ign_run", 1, 5'd5, 0, 1);
        cycle("ign_run", 1, 5'd5, 0, 0);
        cycle("ign_run", 1, 5'd5, 0, 1);
        cycle("ign_run", 1, 5'd5, 0, 1);
        cycle("ign_fin", 1, 5'd5, 0, 0);
        idle("ign_end", 2);

        cycle("mrst", 1, 5'd4, 0, 0);
        cycle("mrst", 0, '0, 0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("mrst_async");
        #2;
        reset_n = 1'b1;
        idle("mrst_after", 3);
        cycle("mrst_one", 1, 5'd1, 0, 0);
        cycle("mrst_one", 0, '0, 0, 1);
        idle("mrst_one_end", 2);

        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] c;
            c = ($urandom_range(0, 3) == 0) ? W'($urandom)
                                            : W'($urandom_range(0, 6));
            cycle("rand",
                  ($urandom_range(0, 3) == 0),
                  c,
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 1) == 1));
        end
        idle("rand_end", 2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Iteration initiator for the microcoded CPU core. Loaded with an iteration count, it issues one step request per iteration to an execution resource (shifter, string unit) over a valid/ack handshake, counting completions down to zero. It reports progress via `step_index` and `remaining`, and signals completion or abort with a one-cycle `done` pulse. It is the driving end of a count-down loop: it produces steps and terminates itself rather than being stepped.

## Interface
- `WIDTH`, default 5: width of the iteration count, step index and remaining count.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a loop. Sampled only in IDLE.
- `count_in` in WIDTH: number of iterations, 0 to 2^WIDTH-1. Sampled with `start`.
- `abort` in 1: terminate the loop early. Honoured only in RUN.
- `step_valid` out 1: step request to the downstream unit.
- `step_ack` in 1: downstream has accepted the current step. Ignored unless `step_valid`=1.
- `step_index` out WIDTH: zero-based number of the current step.
- `remaining` out WIDTH: steps not yet acknowledged.
- `busy` out 1: high in RUN and FINISH.
- `done` out 1: one-cycle pulse in FINISH.
- `aborted` out 1: registered. Set on entering FINISH via abort; cleared on the next accepted `start`.

## Operation
- Three states: IDLE, RUN, FINISH.
- Reset: state IDLE. All outputs are 0: `step_valid`, `step_index`, `remaining`, `busy`, `done`, `aborted`.
- IDLE, `start`=1, `count_in`≠0:
  - `remaining` := `count_in`, `step_index` := 0, `aborted` := 0.
  - Go to RUN.
- IDLE, `start`=1, `count_in`=0:
  - `aborted` := 0, `remaining` := 0.
  - Go directly to FINISH. No step is issued.
- RUN:
  - `step_valid`=1 throughout.
  - `step_valid` never drops without an ack, except on abort.
  - On `step_ack`: `step_index` += 1 and `remaining` -= 1. If `remaining` was 1, go to FINISH.
- RUN, `abort`=1 without `step_ack`: go to FINISH with `aborted` := 1. Counters hold their values.
- RUN, `abort` and `step_ack` in the same cycle:
  - The ack is counted first.
  - If this was the last step, it is a normal finish with `aborted`=0.
  - Otherwise go to FINISH with `aborted`=1.
- FINISH: `done`=1 and `step_valid`=0 for exactly one cycle, then go to IDLE.
- `start` in RUN or FINISH is ignored; there is no queueing.
- `abort` in IDLE or FINISH is ignored.
- `step_index` and `remaining` hold their final values in IDLE until the next accepted `start`.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - `step_index` never exceeds `count_in`-1 while `step_valid`=1.
  - `remaining` never underflows: the decrement happens only in RUN, where `remaining` is ≥ 1.
- `reset_n` asserted in any state: immediate asynchronous return to reset values, including `step_valid`=0 mid-handshake. No `done` is produced for the interrupted loop.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- `start` sampled at edge N:
  - `step_valid`=1 and `busy`=1 from cycle N+1.
  - For `count_in`=0: `done`=1 in N+1, IDLE in N+2.
- Throughput: one step per cycle when `step_ack` is held high. A count of K with ack always high gives:
  - `step_valid` for K cycles (N+1 to N+K),
  - `done` at N+K+1,
  - IDLE at N+K+2, when a new `start` can be accepted.
- Ack latency is unbounded. The sequencer waits in RUN with `step_index` and `remaining` stable.
- Abort sampled at edge M: FINISH in M+1 and `step_valid`=0 in M+1.
- `done` and `step_valid` are never high in the same cycle.

## Test plan
- Basic run, ack held high:
  - Stimulus: reset, `count_in`=3, `start` pulse, `step_ack`=1 constant.
  - Response: `step_valid` for 3 cycles with `step_index` 0,1,2 and `remaining` 3,2,1; `done` one cycle later with `aborted`=0 and `remaining`=0.
- Zero count:
  - Stimulus: `start` with `count_in`=0.
  - Response: `step_valid` never asserts; `done`=1 on the next cycle; `busy` for exactly one cycle.
- Stalled ack:
  - Stimulus: `count_in`=2, ack given 4 cycles after valid for each step.
  - Response: `step_valid` held continuously; `step_index` is stable during each stall; `done` arrives 1 cycle after the second ack.
- Abort:
  - Stimulus: `count_in`=31, ack every cycle, `abort` at the third step; then, separately, `abort` together with the ack of the last step of a `count_in`=2 loop.
  - Response, first case: `done` with `aborted`=1 and `remaining`=28, `step_index`=3.
  - Response, second case: `done` with `aborted`=0 and `remaining`=0.
- Ignored inputs:
  - Stimulus: `start` with `count_in`=5 asserted during RUN and during FINISH.
  - Response: no effect on the counters, and no second loop.
- Mid-loop reset:
  - Stimulus: drop `reset_n` asynchronously (between clock edges) during RUN with `step_valid`=1.
  - Response: all outputs 0 immediately; no `done` pulse after release. A following `start` with `count_in`=1 runs normally.
